// File: rtl/fp_pkg.sv
// Shared types and constants for the FP normalise/round pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the controller state encoding, the default format widths and the
// exponent boundary constants for the default exponent width.
package fp_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;

    // Exponent boundary encodings at the default width. Blocks built with a
    // non-default EXP_W derive their own copies from the same rule.
    localparam logic [DEF_EXP_W-1:0] EXP_ALL_ONES = {DEF_EXP_W{1'b1}};
    localparam logic [DEF_EXP_W-1:0] EXP_ZERO     = {DEF_EXP_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        LSHIFT = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Right-shift-by-one with round-to-nearest-even for a sum with its carry set.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   sum      - unnormalised magnitude {carry, hidden, fraction}, carry is 1
//   frac     - rounded fraction after the one or two right shifts
//   exp_inc2 - rounding overflowed into the carry slot; exponent gets +2
module fp_round_rne #(
    parameter int MAN_W = 23
) (
    input  logic [MAN_W+1:0] sum,
    output logic [MAN_W-1:0] frac,
    output logic             exp_inc2
);

    logic             rnd_up;
    logic [MAN_W+1:0] rounded;

    always_comb begin
        // Only one bit is dropped, so a set dropped bit is always a tie;
        // break it towards the even neighbour.
        rnd_up   = sum[0] & sum[1];
        rounded  = {1'b0, sum[MAN_W+1:1]} + {{(MAN_W+1){1'b0}}, rnd_up};
        exp_inc2 = rounded[MAN_W+1];
        // A round carry leaves exactly 1.000..0 x 2, so the second shift
        // drops only a zero and needs no further rounding.
        frac     = exp_inc2 ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    end

endmodule

// File: rtl/fp_norm_round_seq.sv
// Sequential normaliser/rounder for a floating-point adder result.
// Latency: out_valid 2 edges after acceptance (acceptance edge counted), +1 edge per left shift.
// Backpressure: one result in flight; in_ready only in IDLE, result held in HOLD until out_ready.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   in_valid/in_ready               - input handshake
//   in_sign, in_eff_sub             - adder sign, effective-subtraction flag
//   in_sum, in_exp                  - unnormalised magnitude, aligned exponent
//   out_valid/out_ready             - output handshake
//   out_sign, out_exp, out_frac     - normalised result
//   out_ovf, out_unf, out_zero      - infinity, subnormal, exact zero flags
module fp_norm_round_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic             in_eff_sub,
    input  logic [MAN_W+1:0] in_sum,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_frac,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_zero
);

    localparam int SUM_W = MAN_W + 2;

    // Exponent math is one bit wider than the field so that +1/+2 past the
    // all-ones code is visible instead of wrapping.
    localparam logic [EXP_W:0]   EXP_MAX  = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0]   EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0]   EXP_TWO  = {{(EXP_W-1){1'b0}}, 2'b10};
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

    state_t           state;
    logic             r_sign;
    logic             r_eff_sub;
    logic [SUM_W-1:0] r_sum;
    logic [EXP_W:0]   r_exp;

    // Carry path: right shift with rounding.
    logic [MAN_W-1:0] rnd_frac;
    logic             rnd_inc2;
    logic [EXP_W:0]   carry_exp;

    // Left-shift path; the carry bit is known zero here so it is not carried.
    logic [MAN_W:0]   lsh_sum;
    logic [EXP_W:0]   lsh_exp;

    fp_round_rne #(
        .MAN_W    (MAN_W)
    ) u_round (
        .sum      (r_sum),
        .frac     (rnd_frac),
        .exp_inc2 (rnd_inc2)
    );

    always_comb begin
        carry_exp = r_exp + (rnd_inc2 ? EXP_TWO : EXP_ONE);
        lsh_sum   = {r_sum[MAN_W-1:0], 1'b0};
        lsh_exp   = r_exp - EXP_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            r_sign    <= 1'b0;
            r_eff_sub <= 1'b0;
            r_sum     <= '0;
            r_exp     <= '0;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_frac  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign    <= in_sign;
                        r_eff_sub <= in_eff_sub;
                        r_sum     <= in_sum;
                        r_exp     <= {1'b0, in_exp};
                        in_ready  <= 1'b0;
                        state     <= EVAL;
                    end
                end

                EVAL: begin
                    out_sign <= r_sign;
                    out_ovf  <= 1'b0;
                    out_unf  <= 1'b0;
                    out_zero <= 1'b0;
                    if (r_exp == EXP_MAX) begin
                        out_exp   <= EXP_ONES;
                        out_frac  <= '0;
                        out_ovf   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (r_sum == '0) begin
                        // Exact cancellation yields +0; a true zero sum keeps its sign.
                        out_sign  <= r_eff_sub ? 1'b0 : r_sign;
                        out_exp   <= '0;
                        out_frac  <= '0;
                        out_zero  <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (r_sum[SUM_W-1]) begin
                        if (carry_exp >= EXP_MAX) begin
                            out_exp  <= EXP_ONES;
                            out_frac <= '0;
                            out_ovf  <= 1'b1;
                        end else begin
                            out_exp  <= carry_exp[EXP_W-1:0];
                            out_frac <= rnd_frac;
                        end
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (r_sum[MAN_W]) begin
                        out_exp   <= r_exp[EXP_W-1:0];
                        out_frac  <= r_sum[MAN_W-1:0];
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        state <= LSHIFT;
                    end
                end

                LSHIFT: begin
                    if (r_exp <= EXP_ONE) begin
                        // Arrived already at the bottom of the exponent range.
                        out_exp   <= '0;
                        out_frac  <= r_sum[MAN_W-1:0];
                        out_unf   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        r_sum <= {1'b0, lsh_sum};
                        r_exp <= lsh_exp;
                        // Exit on the same edge as the final shift so each
                        // shift costs exactly one cycle.
                        if (lsh_sum[MAN_W]) begin
                            out_exp   <= lsh_exp[EXP_W-1:0];
                            out_frac  <= lsh_sum[MAN_W-1:0];
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else if (lsh_exp == EXP_ONE) begin
                            out_exp   <= '0;
                            out_frac  <= lsh_sum[MAN_W-1:0];
                            out_unf   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_round_seq.sv
// Directed bench for fp_norm_round_seq (EXP_W=8, MAN_W=23) with a scoreboard.
// Latency is counted in clock edges with the acceptance edge as edge 1.
// Output stability and in_ready are checked every cycle the result is held.
module tb_fp_norm_round_seq;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic        ovf;
        logic        unf;
        logic        zero;
    } res_t;

    typedef struct {
        string name;
        res_t  res;
        int    lat;
        int    acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic        in_eff_sub;
    logic [24:0] in_sum;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic        out_ovf;
    logic        out_unf;
    logic        out_zero;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic prev_vld = 1'b0;
    res_t mon_act;

    fp_norm_round_seq #(
        .EXP_W      (8),
        .MAN_W      (23)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_eff_sub (in_eff_sub),
        .in_sum     (in_sum),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_frac   (out_frac),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic res_t mk(input logic s, input logic [7:0] e, input logic [22:0] f,
                                input logic o, input logic u, input logic z);
        return {s, e, f, o, u, z};
    endfunction

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (out_valid) begin
                mon_act = {out_sign, out_exp, out_frac, out_ovf, out_unf, out_zero};
                if (sb.size() == 0) begin
                    check("spurious out_valid", 64'(out_valid), 64'd0);
                end else begin
                    if (!prev_vld)
                        check({sb[0].name, " latency"}, 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
                    if (out_ready) begin
                        check({sb[0].name, " result"}, 64'(mon_act), 64'(sb[0].res));
                        void'(sb.pop_front());
                    end else begin
                        check({sb[0].name, " held result"}, 64'(mon_act), 64'(sb[0].res));
                        check({sb[0].name, " in_ready while held"}, 64'(in_ready), 64'd0);
                    end
                end
            end
            prev_vld = out_valid;
        end
    end

    task automatic issue(input string name, input logic s, input logic es,
                         input logic [24:0] sum, input logic [7:0] e,
                         input res_t r, input int lat);
        int   n;
        exp_t x;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({name, " in_ready wait"}, 64'(in_ready), 64'd1);
        end else begin
            in_valid   = 1'b1;
            in_sign    = s;
            in_eff_sub = es;
            in_sum     = sum;
            in_exp     = e;
            x.name = name;
            x.res  = r;
            x.lat  = lat;
            x.acc  = cyc + 1;
            sb.push_back(x);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check({sb[0].name, " drain timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic run(input string name, input logic s, input logic es,
                       input logic [24:0] sum, input logic [7:0] e,
                       input res_t r, input int lat);
        issue(name, s, es, sum, e, r, lat);
        drain();
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        in_eff_sub = 1'b0;
        in_sum     = '0;
        in_exp     = '0;
        out_ready  = 1'b1;

        repeat (3) @(negedge clk);
        check("reset outputs",
              64'({out_valid, out_sign, out_exp, out_frac, out_ovf, out_unf, out_zero}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 64'(in_ready), 64'd1);

        //   name            sign sub  sum           exp     expected result                              lat
        run("carry",         0, 0, 25'h1800000, 8'd127, mk(0, 8'd128, 23'h400000, 0, 0, 0), 2);
        run("tie_round_up",  1, 0, 25'h1000003, 8'd100, mk(1, 8'd101, 23'h000002, 0, 0, 0), 2);
        run("tie_even",      0, 0, 25'h1000001, 8'd100, mk(0, 8'd101, 23'h000000, 0, 0, 0), 2);
        run("round_carry",   0, 0, 25'h1FFFFFF, 8'd10,  mk(0, 8'd12,  23'h000000, 0, 0, 0), 2);
        run("passthrough",   1, 1, 25'h0800123, 8'd50,  mk(1, 8'd50,  23'h000123, 0, 0, 0), 2);
        run("cancel",        0, 1, 25'h0000400, 8'd127, mk(0, 8'd114, 23'h000000, 0, 0, 0), 15);
        run("subnormal",     0, 1, 25'h0000001, 8'd5,   mk(0, 8'd0,   23'h000010, 0, 1, 0), 6);
        run("zero_cancel",   1, 1, 25'h0000000, 8'd77,  mk(0, 8'd0,   23'h000000, 0, 0, 1), 2);
        run("zero_signed",   1, 0, 25'h0000000, 8'd3,   mk(1, 8'd0,   23'h000000, 0, 0, 1), 2);
        run("overflow",      0, 0, 25'h1800000, 8'd254, mk(0, 8'd255, 23'h000000, 1, 0, 0), 2);
        run("ovf_round",     1, 0, 25'h1FFFFFF, 8'd253, mk(1, 8'd255, 23'h000000, 1, 0, 0), 2);
        run("exp_all_ones",  0, 0, 25'h0900000, 8'd255, mk(0, 8'd255, 23'h000000, 1, 0, 0), 2);

        // Backpressure: result must sit unchanged while out_ready is low.
        out_ready = 1'b0;
        issue("backpressure", 0, 0, 25'h0A00000, 8'd60, mk(0, 8'd60, 23'h200000, 0, 0, 0), 2);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("backpressure valid timeout", 64'(out_valid), 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset in the middle of a long left-shift sequence.
        issue("reset_mid", 0, 1, 25'h0000400, 8'd127, mk(0, 8'd114, 23'h000000, 0, 0, 0), 15);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("out_valid in reset", 64'(out_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after mid reset", 64'(in_ready), 64'd1);
        check("out_valid after mid reset", 64'(out_valid), 64'd0);
        repeat (20) @(negedge clk);
        check("no stale result", 64'(out_valid), 64'd0);

        run("post_reset",    0, 1, 25'h0400001, 8'd20,  mk(0, 8'd19,  23'h000002, 0, 0, 0), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_norm_round_seq.md
FP_NORM_ROUND_SEQ -- requirements
Module: fp_norm_round_seq

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 The block SHALL have parameter MAN_W, default 23, stored-fraction width; the raw sum width is MAN_W+2 (carry, hidden, fraction).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, upstream result valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, block can accept an input.
REQ-007 The block SHALL have port in_sign, input, 1 bit, result sign from the adder.
REQ-008 The block SHALL have port in_eff_sub, input, 1 bit, high when operand signs differ (effective subtraction).
REQ-009 The block SHALL have port in_sum, input, MAN_W+2 bits, unnormalised magnitude with carry bit at MAN_W+1.
REQ-010 The block SHALL have port in_exp, input, EXP_W bits, aligned (larger) exponent.
REQ-011 The block SHALL have port out_valid, output, 1 bit, result valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit, downstream accepts the result.
REQ-013 The block SHALL have ports out_sign (1 bit), out_exp (EXP_W bits) and out_frac (MAN_W bits), all outputs, giving the normalised result.
REQ-014 The block SHALL have ports out_ovf, out_unf and out_zero, all outputs, 1 bit each: overflow/infinity, subnormal result, and exact zero.

Function
REQ-015 The state machine SHALL have states IDLE, EVAL, LSHIFT and HOLD.
REQ-016 in_ready SHALL be 1 only in IDLE; an input is accepted on an edge where in_valid and in_ready are both 1, and registers move to EVAL.
REQ-017 In EVAL, if in_exp is all-ones, the block SHALL produce exp all-ones, frac 0 and out_ovf=1, then go to HOLD.
REQ-018 In EVAL, if in_sum is 0, the block SHALL produce exp 0, frac 0 and out_zero=1, with sign = in_eff_sub ? 0 : in_sign, then go to HOLD.
REQ-019 In EVAL, if the carry bit is 1, the block SHALL shift right 1, set exp+1 and round-to-nearest-even on the dropped bit (round up only if the dropped bit and the new LSB are both 1).
REQ-020 If that rounding carries into bit MAN_W+1, the block SHALL shift right once more and set exp+1, all within the same EVAL cycle.
REQ-021 If exp+1 (or +2) reaches all-ones, the block SHALL set out_ovf=1 and frac 0; the result then goes to HOLD.
REQ-022 In EVAL, if the hidden bit is 1 and the carry bit is 0, the result SHALL pass unchanged to HOLD.
REQ-023 In EVAL, if both hidden and carry bits are 0, the block SHALL go to LSHIFT.
REQ-024 Each LSHIFT cycle SHALL shift left 1 and set exp-1, while the hidden bit is 0 and exp>1.
REQ-025 LSHIFT SHALL exit to HOLD when the hidden bit is 1 (normal result).
REQ-026 LSHIFT SHALL exit to HOLD when exp==1 with the hidden bit still 0, outputting exp 0, frac = low MAN_W bits and out_unf=1.
REQ-027 Latency SHALL be: out_valid rises 2 edges after acceptance, plus n edges for n left shifts (maximum MAN_W+2).
REQ-028 In HOLD, out_valid SHALL be 1 and all outputs SHALL be held stable until out_ready=1; then the state returns to IDLE, with no bypass to EVAL on the same edge.
REQ-029 All exponent arithmetic SHALL be done in EXP_W+1 bits so that overflow is detected before any wrap.

Reset
REQ-030 rst_n=0 SHALL force IDLE immediately, including mid-LSHIFT or in HOLD; the pending result is discarded.
REQ-031 The reset value SHALL be 0 for every output except in_ready, which is 1 after reset is released.

Structure
REQ-032 Package fp_pkg SHALL hold the state enum, the default EXP_W/MAN_W, and the exponent all-ones/zero constants derived from EXP_W.
REQ-033 Round-to-nearest-even SHALL be a combinational sub-module fp_round_rne, instantiated once in the EVAL datapath.

Verification (MAN_W=23, EXP_W=8)
REQ-034 Carry case: in_sum=0x1800000, exp=127, eff_sub=0 -> exp 128, frac 0x400000, out_valid 2 edges after accept.
REQ-035 Tie round: in_sum=0x1000003, exp=100 -> frac 0x000002, exp 101; in_sum=0x1000001 -> frac 0x000000 (even), exp 101.
REQ-036 Cancellation: in_sum=0x0000400, exp=127, eff_sub=1 -> 13 shifts, exp 114, frac 0, out_valid 15 edges after accept.
REQ-037 Underflow/zero: in_sum=0x0000001, exp=5 -> exp 0, frac 0x000010, out_unf=1; in_sum=0, eff_sub=1, sign=1 -> out_zero=1, sign 0.
REQ-038 Overflow: in_sum=0x1800000, exp=254 -> exp 255, frac 0, out_ovf=1.
REQ-039 Backpressure and reset: out_ready low 5 cycles -> outputs stable and in_ready=0; rst_n pulsed during LSHIFT -> IDLE, out_valid=0, in_ready=1 after release.
